// File: rtl/enet_pkg.sv
// Shared types for the enet packet datapath.
// Write-side FSM encoding and drop counter width.
package enet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/enet_fifo_ram.sv
// Frame FIFO storage: registered write port,
// asynchronous read port for first-word-fall-through.
module enet_fifo_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/enet_pkt_fifo.sv
// Frame-aware FIFO: reader sees only committed frames;
// frames are rewound on abort and dropped on overflow.
module enet_pkt_fifo
  import enet_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 64,
  parameter int AFULL_MARGIN = 4,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_push,
  input  logic                  wr_eop,
  input  logic                  wr_abort,
  output logic                  wr_full,
  output logic                  wr_afull,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_eop,
  input  logic                  rd_pop,
  output logic                  rd_empty,
  output logic [AW:0]           level,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  rd_underflow
);

  localparam logic [AW:0] DEPTH_P  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MARGIN_P = (AW+1)'(AFULL_MARGIN);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [DROP_CNT_W-1:0] CNT_ONE = 1;

  logic [AW:0]    wr_ptr;
  logic [AW:0]    cm_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    used;
  logic [WIDTH:0] rd_word;
  wr_state_e      state;
  logic           wr_open;
  logic           push_ok;
  logic           push_ovf;
  logic           pop_ok;

  assign used     = wr_ptr - rd_ptr;
  assign wr_full  = (used == DEPTH_P);
  assign wr_afull = ((DEPTH_P - used) <= MARGIN_P);
  assign rd_empty = (rd_ptr == cm_ptr);
  assign level    = cm_ptr - rd_ptr;

  assign wr_open  = wr_push && !wr_abort && (state != ST_DROP);
  assign push_ok  = wr_open && !wr_full;
  assign push_ovf = wr_open && wr_full;
  assign pop_ok   = rd_pop && !rd_empty;

  assign {rd_eop, rd_data} = rd_word;

  enet_fifo_ram #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_eop, wr_data}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  // Full is judged on pre-edge pointers, so a coincident pop never rescues a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      state    <= ST_IDLE;
      drop_cnt <= '0;
    end else if (wr_abort) begin
      wr_ptr <= cm_ptr;
      state  <= ST_IDLE;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (wr_eop) begin
        cm_ptr <= wr_ptr + PTR_ONE;
        state  <= ST_IDLE;
      end else begin
        state  <= ST_ACTIVE;
      end
    end else if (push_ovf) begin
      wr_ptr <= cm_ptr;
      state  <= wr_eop ? ST_IDLE : ST_DROP;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
    end else if (wr_push && wr_eop && state == ST_DROP) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      rd_underflow <= 1'b0;
    end else if (pop_ok) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end else if (rd_pop) begin
      rd_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enet_pkt_fifo.sv
// Bench for enet_pkt_fifo: queue-level frame model checked
// every cycle, plus directed literal expectations.
module tb_enet_pkt_fifo;

  localparam int W = 8;
  localparam int D = 16;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_push = 1'b0;
  logic         wr_eop = 1'b0;
  logic         wr_abort = 1'b0;
  logic         wr_full;
  logic         wr_afull;
  logic [W-1:0] rd_data;
  logic         rd_eop;
  logic         rd_pop = 1'b0;
  logic         rd_empty;
  logic [4:0]   level;
  logic [15:0]  drop_cnt;
  logic         rd_underflow;

  int vectors = 0;
  int miscompares = 0;

  enet_pkt_fifo #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_MARGIN (M)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_push      (wr_push),
    .wr_eop       (wr_eop),
    .wr_abort     (wr_abort),
    .wr_full      (wr_full),
    .wr_afull     (wr_afull),
    .rd_data      (rd_data),
    .rd_eop       (rd_eop),
    .rd_pop       (rd_pop),
    .rd_empty     (rd_empty),
    .level        (level),
    .drop_cnt     (drop_cnt),
    .rd_underflow (rd_underflow)
  );

  always #5 clk = ~clk;

  // Model: committed words and the open frame as queues of {eop,data}.
  logic [8:0] cq[$];
  logic [8:0] pq[$];
  bit         m_dropping;
  bit         m_uflow;
  int         m_dc;

  always @(posedge clk or negedge rst_n) begin
    int  u;
    bit  full;
    if (!rst_n) begin
      cq.delete();
      pq.delete();
      m_dropping = 0;
      m_uflow = 0;
      m_dc = 0;
    end else begin
      u = cq.size() + pq.size();
      full = (u == D);
      if (rd_pop) begin
        if (cq.size() > 0) void'(cq.pop_front());
        else m_uflow = 1;
      end
      if (wr_abort) begin
        pq.delete();
        m_dropping = 0;
      end else if (wr_push) begin
        if (m_dropping) begin
          if (wr_eop) m_dropping = 0;
        end else if (full) begin
          pq.delete();
          if (m_dc < 65535) m_dc++;
          m_dropping = !wr_eop;
        end else begin
          pq.push_back({wr_eop, wr_data});
          if (wr_eop) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int  u;
    bit  e_empty, e_full, e_af, bad;
    u = cq.size() + pq.size();
    e_empty = (cq.size() == 0);
    e_full = (u == D);
    e_af = ((D - u) <= M);
    bad = (rd_empty !== e_empty) || (level !== 5'(cq.size()))
       || (wr_full !== e_full) || (wr_afull !== e_af)
       || (drop_cnt !== 16'(m_dc)) || (rd_underflow !== m_uflow);
    if (!e_empty)
      bad = bad || ({rd_eop, rd_data} !== cq[0]);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL model t=%0t got e=%b l=%0d f=%b af=%b dc=%0d uf=%b w=%h want e=%b l=%0d f=%b af=%b dc=%0d uf=%b w=%h",
        $time, rd_empty, level, wr_full, wr_afull, drop_cnt, rd_underflow,
        {rd_eop, rd_data}, e_empty, cq.size(), e_full, e_af, m_dc, m_uflow,
        e_empty ? 9'h0 : cq[0]);
    end
  end

  task automatic lit(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive(bit p, bit e, logic [7:0] d, bit a, bit r);
    wr_push = p;
    wr_eop = e;
    wr_data = d;
    wr_abort = a;
    rd_pop = r;
    @(posedge clk);
    #1;
    wr_push = 0;
    wr_eop = 0;
    wr_abort = 0;
    rd_pop = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && !rd_empty; i++) drive(0, 0, 0, 0, 1);
    lit("drain", rd_empty, 1);
  endtask

  initial begin
    int len, k, guard;
    bit p;
    @(posedge clk);
    #1 rst_n = 1;
    lit("rst_empty", rd_empty, 1);
    lit("rst_level", level, 0);
    lit("rst_full", wr_full, 0);
    lit("rst_afull", wr_afull, 0);
    lit("rst_uf", rd_underflow, 0);

    // underflow
    drive(0, 0, 0, 0, 1);
    lit("uf_set", rd_underflow, 1);
    lit("uf_level", level, 0);

    // basic frame
    drive(1, 0, 8'h11, 0, 0);
    lit("b_empty1", rd_empty, 1);
    drive(1, 0, 8'h22, 0, 0);
    lit("b_empty2", rd_empty, 1);
    drive(1, 1, 8'h33, 0, 0);
    lit("b_empty3", rd_empty, 0);
    lit("b_level", level, 3);
    lit("b_d0", {rd_eop, rd_data}, 9'h011);
    drive(0, 0, 0, 0, 1);
    lit("b_d1", {rd_eop, rd_data}, 9'h022);
    drive(0, 0, 0, 0, 1);
    lit("b_d2", {rd_eop, rd_data}, 9'h133);
    drive(0, 0, 0, 0, 1);
    lit("b_end", rd_empty, 1);

    // abort
    drive(1, 0, 8'hA0, 0, 0);
    drive(1, 0, 8'hA1, 0, 0);
    drive(1, 0, 8'hA2, 1, 0);
    drive(1, 1, 8'hB0, 0, 0);
    lit("a_level", level, 1);
    lit("a_data", {rd_eop, rd_data}, 9'h1B0);
    lit("a_dc", drop_cnt, 0);
    drain();

    // overflow drop
    for (int i = 0; i < 10; i++) drive(1, i == 9, 8'(i), 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'(8'h40 + i), 0, 0);
      if (i == 4) lit("o_full5", wr_full, 0);
    end
    lit("o_full6", wr_full, 1);
    drive(1, 1, 8'h46, 0, 0);
    lit("o_dc", drop_cnt, 1);
    lit("o_level", level, 10);
    lit("o_full7", wr_full, 0);
    for (int i = 0; i < 10; i++) begin
      lit("o_data", {rd_eop, rd_data}, {i == 9, 8'(i)});
      drive(0, 0, 0, 0, 1);
    end
    drive(1, 0, 8'hC0, 0, 0);
    drive(1, 1, 8'hC1, 0, 0);
    lit("o_next", level, 2);
    drain();

    // oversize frame
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 19, 8'(8'h80 + i), 0, 0);
      if (i == 10) lit("s_af11", wr_afull, 0);
      if (i == 11) lit("s_af12", wr_afull, 1);
      if (i == 15) lit("s_full", wr_full, 1);
      if (i == 16) lit("s_af17", wr_afull, 0);
      lit("s_empty", rd_empty, 1);
    end
    lit("s_dc", drop_cnt, 2);
    lit("s_level", level, 0);

    // random frames with random pops
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 8);
      k = 0;
      guard = 0;
      while (k < len && guard < 1000) begin
        p = ($urandom_range(0, 3) != 0);
        drive(p, p && (k == len - 1), 8'($urandom), $urandom_range(0, 63) == 0,
              $urandom_range(0, 1) == 1);
        if (p) k++;
        guard++;
      end
      lit("r_guard", guard < 1000, 1);
    end
    drain();

    // async reset mid-frame
    drive(1, 0, 8'h55, 0, 0);
    drive(1, 0, 8'h56, 0, 0);
    #2 rst_n = 0;
    #1;
    lit("ar_empty", rd_empty, 1);
    lit("ar_level", level, 0);
    lit("ar_dc", drop_cnt, 0);
    lit("ar_uf", rd_underflow, 0);
    lit("ar_full", wr_full, 0);
    @(posedge clk);
    #1 rst_n = 1;
    drive(1, 1, 8'h77, 0, 0);
    lit("ar_post", {rd_eop, rd_data}, 9'h177);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
